// File: rtl/bf16_issue_ctrl.sv
// bf16_issue_ctrl: credit-based issue controller for a fixed-latency bf16 arithmetic unit.
// Requests are queued in a command FIFO. Each request is issued to the unit as registered
// operands and then tracked through a LATENCY-deep {valid,tag} pipe. When it completes, its
// result is captured into a response FIFO and returned to the caller in issue order.
//
// Ports:
//   clk, reset                    clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_in1..3, req_funct5        bf16 operands and opaque opcode
//   req_tag                       caller tag, returned with the response
//   u_in1..3, u_funct5            registered operands/opcode to the arithmetic unit
//   u_result                      unit result, valid LATENCY edges after the issue edge
//   rsp_valid/rsp_ready           response handshake
//   rsp_result, rsp_tag           oldest completed result and its tag
//   busy                          any entry queued, in flight or awaiting response
module bf16_issue_ctrl #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned TAG_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [15:0]      req_in1,
    input  logic [15:0]      req_in2,
    input  logic [15:0]      req_in3,
    input  logic [4:0]       req_funct5,
    input  logic [TAG_W-1:0] req_tag,
    output logic [15:0]      u_in1,
    output logic [15:0]      u_in2,
    output logic [15:0]      u_in3,
    output logic [4:0]       u_funct5,
    input  logic [15:0]      u_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned OW    = $clog2(DEPTH + LATENCY + 1);
    localparam int unsigned CMD_W = 3 * 16 + 5 + TAG_W;
    localparam int unsigned RSP_W = 16 + TAG_W;

    // Command FIFO entry layout: {in1, in2, in3, funct5, tag}
    logic [CMD_W-1:0] cmd_mem [DEPTH];
    logic [PW-1:0]    cmd_wr_q, cmd_rd_q;
    logic [CW-1:0]    cmd_cnt_q;
    logic [CMD_W-1:0] cmd_head;
    logic             cmd_push;

    // Response FIFO entry layout: {result, tag}
    logic [RSP_W-1:0] rsp_mem [DEPTH];
    logic [PW-1:0]    rsp_wr_q, rsp_rd_q;
    logic [CW-1:0]    rsp_cnt_q;
    logic [RSP_W-1:0] rsp_head;
    logic             rsp_push, rsp_pop;

    logic [LATENCY-1:0] pipe_valid_q;
    logic [TAG_W-1:0]   pipe_tag_q [LATENCY];

    logic [OW-1:0] occupancy;
    logic          credit, issue;

    always_comb begin
        cmd_head  = cmd_mem[cmd_rd_q];
        rsp_head  = rsp_mem[rsp_rd_q];
        req_ready = (cmd_cnt_q != CW'(DEPTH));
        cmd_push  = req_valid && req_ready;
        rsp_valid = (rsp_cnt_q != '0);
        rsp_pop   = rsp_valid && rsp_ready;
        rsp_push  = pipe_valid_q[LATENCY-1];

        // Every in-flight op owns a response slot, so a completing op can never find the
        // response FIFO full. A pop on this edge does not free credit until the next one.
        occupancy = OW'(rsp_cnt_q);
        for (int i = 0; i < LATENCY; i++) begin
            occupancy = occupancy + OW'(pipe_valid_q[i]);
        end
        credit = (occupancy < OW'(DEPTH));
        issue  = (cmd_cnt_q != '0) && credit;

        // Gate the head so the outputs read zero whenever the FIFO is empty.
        rsp_result = rsp_valid ? rsp_head[RSP_W-1:TAG_W] : '0;
        rsp_tag    = rsp_valid ? rsp_head[TAG_W-1:0] : '0;
        busy       = (cmd_cnt_q != '0) || (|pipe_valid_q) || rsp_valid;
    end

    // Storage arrays need no reset: the counts alone decide what is visible.
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wr_q] <= {req_in1, req_in2, req_in3, req_funct5, req_tag};
        end
        if (rsp_push) begin
            rsp_mem[rsp_wr_q] <= {u_result, pipe_tag_q[LATENCY-1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_wr_q     <= '0;
            cmd_rd_q     <= '0;
            cmd_cnt_q    <= '0;
            rsp_wr_q     <= '0;
            rsp_rd_q     <= '0;
            rsp_cnt_q    <= '0;
            pipe_valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag_q[i] <= '0;
            end
            u_in1    <= '0;
            u_in2    <= '0;
            u_in3    <= '0;
            u_funct5 <= '0;
        end else begin
            if (cmd_push) cmd_wr_q <= cmd_wr_q + PW'(1);
            if (issue)    cmd_rd_q <= cmd_rd_q + PW'(1);
            cmd_cnt_q <= cmd_cnt_q + CW'(cmd_push) - CW'(issue);

            if (rsp_push) rsp_wr_q <= rsp_wr_q + PW'(1);
            if (rsp_pop)  rsp_rd_q <= rsp_rd_q + PW'(1);
            rsp_cnt_q <= rsp_cnt_q + CW'(rsp_push) - CW'(rsp_pop);

            pipe_valid_q[0] <= issue;
            pipe_tag_q[0]   <= cmd_head[TAG_W-1:0];
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_tag_q[i]   <= pipe_tag_q[i-1];
            end

            // Non-issue cycles present a zero bubble to the unit.
            if (issue) begin
                {u_in1, u_in2, u_in3, u_funct5} <= cmd_head[CMD_W-1:TAG_W];
            end else begin
                {u_in1, u_in2, u_in3, u_funct5} <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bf16_issue_ctrl.sv
// Self-checking bench for bf16_issue_ctrl (DEPTH=4, LATENCY=3, TAG_W=4).
// The arithmetic unit is replaced by an echo: u_result returns u_in1 in time for the
// push edge LATENCY edges after issue.
`timescale 1ns/1ps
module tb_bf16_issue_ctrl;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned LATENCY = 3;
    localparam int unsigned TAG_W   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [15:0]      req_in1, req_in2, req_in3;
    logic [4:0]       req_funct5;
    logic [TAG_W-1:0] req_tag;
    logic [15:0]      u_in1, u_in2, u_in3;
    logic [4:0]       u_funct5;
    logic [15:0]      u_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;

    bf16_issue_ctrl #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY),
        .TAG_W   (TAG_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .req_in3    (req_in3),
        .req_funct5 (req_funct5),
        .req_tag    (req_tag),
        .u_in1      (u_in1),
        .u_in2      (u_in2),
        .u_in3      (u_in3),
        .u_funct5   (u_funct5),
        .u_result   (u_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_tag    (rsp_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Echo unit: operands registered at the issue edge appear on u_result before the
    // LATENCY-th following edge.
    logic [15:0] echo [LATENCY-1];
    always @(posedge clk) begin
        echo[0] <= u_in1;
        for (int i = 1; i < LATENCY - 1; i++) echo[i] <= echo[i-1];
    end
    assign u_result = echo[LATENCY-2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitors on the falling edge: record response pops and issue cycles.
    logic [15:0]      pop_res [$];
    logic [TAG_W-1:0] pop_tag [$];
    int               issue_cyc [$];
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            pop_res.push_back(rsp_result);
            pop_tag.push_back(rsp_tag);
        end
        if (!reset && u_in1 != 16'h0) issue_cyc.push_back(cyc);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        pop_res.delete();
        pop_tag.delete();
        issue_cyc.delete();
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input logic [4:0] f, input logic [TAG_W-1:0] t);
        int n = 0;
        req_valid  = 1'b1;
        req_in1    = a;
        req_in2    = b;
        req_in3    = c;
        req_funct5 = f;
        req_tag    = t;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        if (!req_ready) check("send_timeout", 32'(req_ready), 32'd1);
        step();
        req_valid  = 1'b0;
        // Junk on the request fields while req_valid is low must be ignored.
        req_in1    = 16'($urandom);
        req_in2    = 16'($urandom);
        req_in3    = 16'($urandom);
        req_funct5 = 5'($urandom);
        req_tag    = TAG_W'($urandom);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            step();
            n++;
        end
        if (busy) check(name, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [15:0]      in1;
        logic [15:0]      in2;
        logic [15:0]      in3;
        logic [4:0]       funct5;
        logic [TAG_W-1:0] tag;
        logic [15:0]      exp_result;
        logic [TAG_W-1:0] exp_tag;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{16'h3F80, 16'h0000, 16'h0000, 5'h00, 4'h5, 16'h3F80, 4'h5};
        vecs[1] = '{16'h4049, 16'h4000, 16'hBF80, 5'h03, 4'h9, 16'h4049, 4'h9};
        vecs[2] = '{16'hFFFF, 16'h7F80, 16'h0001, 5'h1F, 4'hF, 16'hFFFF, 4'hF};
        vecs[3] = '{16'h0001, 16'h1234, 16'h5678, 5'h0A, 4'h0, 16'h0001, 4'h0};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_in1    = '0;
        req_in2    = '0;
        req_in3    = '0;
        req_funct5 = '0;
        req_tag    = '0;
        rsp_ready  = 1'b1;
        #2;
        check("rst_req_ready",  32'(req_ready),  32'd1);
        check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_rsp_tag",    32'(rsp_tag),    32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_u_in1",      32'(u_in1),      32'd0);
        step();
        step();
        reset = 1'b0;

        // Single ops from the table, one at a time.
        for (int i = 0; i < 4; i++) begin
            int n;
            send(vecs[i].in1, vecs[i].in2, vecs[i].in3, vecs[i].funct5, vecs[i].tag);
            check($sformatf("v%0d_busy_queued", i), 32'(busy), 32'd1);
            step();
            check($sformatf("v%0d_u_in1", i),    32'(u_in1),    32'(vecs[i].in1));
            check($sformatf("v%0d_u_in2", i),    32'(u_in2),    32'(vecs[i].in2));
            check($sformatf("v%0d_u_in3", i),    32'(u_in3),    32'(vecs[i].in3));
            check($sformatf("v%0d_u_funct5", i), 32'(u_funct5), 32'(vecs[i].funct5));
            n = 0;
            while (!rsp_valid && n < 20) begin
                step();
                n++;
            end
            check($sformatf("v%0d_latency", i),    32'(n),          32'(LATENCY));
            check($sformatf("v%0d_bubble_in1", i), 32'(u_in1),      32'd0);
            check($sformatf("v%0d_bubble_f5", i),  32'(u_funct5),   32'd0);
            check($sformatf("v%0d_result", i),     32'(rsp_result), 32'(vecs[i].exp_result));
            check($sformatf("v%0d_tag", i),        32'(rsp_tag),    32'(vecs[i].exp_tag));
            step();
            check($sformatf("v%0d_rsp_gone", i),   32'(rsp_valid),  32'd0);
            check($sformatf("v%0d_idle", i),       32'(busy),       32'd0);
        end

        // Back-to-back stream of 8 with rsp_ready high.
        clear_mon();
        for (int i = 0; i < 8; i++) send(16'h4000 + 16'(i), 16'h0, 16'h0, 5'h0, TAG_W'(i));
        wait_idle("b2b_timeout", 100);
        check("b2b_count", 32'(pop_res.size()), 32'd8);
        for (int i = 0; i < 8 && i < pop_res.size(); i++) begin
            check($sformatf("b2b_res%0d", i), 32'(pop_res[i]), 32'(16'h4000 + 16'(i)));
            check($sformatf("b2b_tag%0d", i), 32'(pop_tag[i]), 32'(i));
        end
        check("b2b_issues", 32'(issue_cyc.size()), 32'd8);
        for (int k = 0; k < 3 && k + 1 < issue_cyc.size(); k++) begin
            check($sformatf("b2b_issue_gap%0d", k), 32'(issue_cyc[k+1] - issue_cyc[k]), 32'd1);
        end

        // Backpressure: no response consumption, credit stops issue at DEPTH.
        clear_mon();
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(16'h5000 + 16'(i), 16'h0, 16'h0, 5'h1, TAG_W'(8 + i));
        repeat (6) step();
        check("bp_issued4",    32'(issue_cyc.size()), 32'd4);
        check("bp_rsp_valid",  32'(rsp_valid),        32'd1);
        check("bp_head",       32'(rsp_result),       32'h5000);
        check("bp_head_tag",   32'(rsp_tag),          32'd8);
        check("bp_ready_2q",   32'(req_ready),        32'd1);
        send(16'h5006, 16'h0, 16'h0, 5'h1, 4'd14);
        send(16'h5007, 16'h0, 16'h0, 5'h1, 4'd15);
        check("bp_full_ready", 32'(req_ready),        32'd0);
        req_valid = 1'b1;
        req_in1   = 16'h50FF;
        repeat (3) step();
        check("bp_still_full", 32'(req_ready),        32'd0);
        check("bp_no_issue",   32'(issue_cyc.size()), 32'd4);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle("bp_timeout", 200);
        check("bp_count", 32'(pop_res.size()), 32'd8);
        for (int i = 0; i < 8 && i < pop_res.size(); i++) begin
            check($sformatf("bp_res%0d", i), 32'(pop_res[i]), 32'(16'h5000 + 16'(i)));
            check($sformatf("bp_tag%0d", i), 32'(pop_tag[i]), 32'(8 + i));
        end

        // Response FIFO at 3: pop and push on the same edge.
        clear_mon();
        rsp_ready = 1'b0;
        send(16'h6001, 16'h0, 16'h0, 5'h2, 4'd1);
        send(16'h6002, 16'h0, 16'h0, 5'h2, 4'd2);
        send(16'h6003, 16'h0, 16'h0, 5'h2, 4'd3);
        repeat (8) step();
        send(16'h6004, 16'h0, 16'h0, 5'h2, 4'd4);
        step();
        check("pp_issue_d", 32'(u_in1), 32'h6004);
        step();
        step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("pp_one_pop", 32'(pop_res.size()), 32'd1);
        check("pp_head",    32'(rsp_result),     32'h6002);
        check("pp_head_tag", 32'(rsp_tag),       32'd2);
        rsp_ready = 1'b1;
        wait_idle("pp_timeout", 50);
        check("pp_count", 32'(pop_res.size()), 32'd4);
        for (int i = 0; i < 4 && i < pop_res.size(); i++) begin
            check($sformatf("pp_res%0d", i), 32'(pop_res[i]), 32'(16'h6001 + 16'(i)));
            check($sformatf("pp_tag%0d", i), 32'(pop_tag[i]), 32'(1 + i));
        end

        // Reset with two ops in flight and one queued.
        clear_mon();
        rsp_ready = 1'b0;
        send(16'h7001, 16'h0, 16'h0, 5'h3, 4'd1);
        send(16'h7002, 16'h0, 16'h0, 5'h3, 4'd2);
        send(16'h7003, 16'h0, 16'h0, 5'h3, 4'd3);
        check("mr_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mr_req_ready",  32'(req_ready),  32'd1);
        check("mr_rsp_valid",  32'(rsp_valid),  32'd0);
        check("mr_rsp_result", 32'(rsp_result), 32'd0);
        check("mr_rsp_tag",    32'(rsp_tag),    32'd0);
        check("mr_busy",       32'(busy),       32'd0);
        check("mr_u_in1",      32'(u_in1),      32'd0);
        check("mr_u_funct5",   32'(u_funct5),   32'd0);
        step();
        step();
        reset     = 1'b0;
        rsp_ready = 1'b1;
        begin
            int seen = 0;
            repeat (10) begin
                step();
                if (rsp_valid) seen++;
            end
            check("mr_no_rsp", 32'(seen), 32'd0);
        end
        check("mr_idle", 32'(busy), 32'd0);

        // First request accepted on the first edge after reset release.
        reset = 1'b1;
        step();
        reset      = 1'b0;
        req_valid  = 1'b1;
        req_in1    = 16'h3C00;
        req_in2    = 16'h0;
        req_in3    = 16'h0;
        req_funct5 = 5'h4;
        req_tag    = 4'd7;
        check("fr_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        check("fr_accepted", 32'(busy), 32'd1);
        step();
        check("fr_u_in1", 32'(u_in1), 32'h3C00);
        begin
            int n = 0;
            while (!rsp_valid && n < 20) begin
                step();
                n++;
            end
        end
        check("fr_result", 32'(rsp_result), 32'h3C00);
        check("fr_tag",    32'(rsp_tag),    32'd7);
        step();
        check("fr_idle",   32'(busy),       32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

endmodule
